// File: rtl/nn_mem_pkg.sv
// Shared types and sizing helpers for the layer-engine data memories.
package nn_mem_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  localparam int DEFAULT_DATA_W = 16;
  localparam int INPUT_DEPTH    = 576;
  localparam int FILTER_DEPTH   = 9;

  // At least one address bit, even for a single-word store.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/buffer_ram_rdpipe.sv
// READ_LAT-deep valid/data shift register; the last stage holds its data
// between results and every valid stage is flushed by reset.
module buffer_ram_rdpipe #(
  parameter int DATA_W   = 16,
  parameter int READ_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic [READ_LAT-1:0] valid_d, valid_q;
  logic [DATA_W-1:0]   data_d [READ_LAT];
  logic [DATA_W-1:0]   data_q [READ_LAT];

  always_comb begin
    valid_d    = '0;
    valid_d[0] = in_valid;
    if (in_valid) begin
      data_d[0] = in_data;
    end else begin
      data_d[0] = data_q[0];
    end
    for (int i = 1; i < READ_LAT; i++) begin
      valid_d[i] = valid_q[i-1];
      if (valid_q[i-1]) begin
        data_d[i] = data_q[i-1];
      end else begin
        data_d[i] = data_q[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < READ_LAT; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < READ_LAT; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign out_valid = valid_q[READ_LAT-1];
  assign out_data  = data_q[READ_LAT-1];

endmodule

// File: rtl/buffer_ram.sv
// Parametrised single-port data memory with zero-fill sweep and pipelined reads.
// Optional macro BUFFER_RAM_PRELOAD_EN: skip the reset sweep so existing contents survive.
module buffer_ram
  import nn_mem_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int DEPTH    = INPUT_DEPTH,
  parameter int ADDR_W   = addr_width(DEPTH),
  parameter int READ_LAT = 1
`ifdef BUFFER_RAM_PRELOAD_EN
  ,
  parameter string INIT_FILE = "input.hex"
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  input  logic              clear,
  output logic              ready,
  output logic              read_valid,
  output logic [DATA_W-1:0] read_data,
  output logic              busy,
  output logic              oob_error
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

`ifdef BUFFER_RAM_PRELOAD_EN
  localparam logic PRELOAD = 1'b1;
`else
  localparam logic PRELOAD = 1'b0;
`endif

  state_e            state_d, state_q;
  logic [ADDR_W-1:0] clear_ptr_d, clear_ptr_q;
  logic              ready_d, ready_q;
  logic              busy_d, busy_q;
  logic              oob_d, oob_q;

  logic              accept_s, addr_oob_s, rd_fire_s;
  logic [ADDR_W-1:0] rd_idx_s;
  logic [DATA_W-1:0] rd_word_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_waddr_s;
  logic [DATA_W-1:0] mem_wdata_s;

  // A clear pulse pre-empts any access requested in the same cycle.
  assign accept_s   = req && ready_q && !clear && !reset;
  assign addr_oob_s = ({1'b0, address} >= DEPTH_X);
  assign rd_fire_s  = accept_s && !write;
  assign rd_idx_s   = addr_oob_s ? '0 : address;
  assign rd_word_s  = addr_oob_s ? '0 : mem[rd_idx_s];

  always_comb begin
    state_d     = state_q;
    clear_ptr_d = clear_ptr_q;
    ready_d     = ready_q;
    busy_d      = busy_q;
    oob_d       = oob_q | (accept_s & addr_oob_s);
    mem_we_s    = 1'b0;
    mem_waddr_s = address;
    mem_wdata_s = write_data;
    case (state_q)
      ST_CLEAR: begin
        mem_we_s    = 1'b1;
        mem_waddr_s = clear_ptr_q;
        mem_wdata_s = '0;
        if (clear_ptr_q == LAST_PTR) begin
          state_d     = ST_IDLE;
          clear_ptr_d = '0;
          ready_d     = 1'b1;
          busy_d      = 1'b0;
        end else begin
          clear_ptr_d = clear_ptr_q + ADDR_W'(1);
        end
      end
      ST_IDLE: begin
        if (clear) begin
          state_d     = ST_CLEAR;
          clear_ptr_d = '0;
          ready_d     = 1'b0;
          busy_d      = 1'b1;
        end else begin
          ready_d  = 1'b1;
          busy_d   = 1'b0;
          mem_we_s = accept_s && write && !addr_oob_s;
        end
      end
      default: begin
        state_d     = ST_CLEAR;
        clear_ptr_d = '0;
        ready_d     = 1'b0;
        busy_d      = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= PRELOAD ? ST_IDLE : ST_CLEAR;
      clear_ptr_q <= '0;
      ready_q     <= PRELOAD;
      busy_q      <= !PRELOAD;
      oob_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      clear_ptr_q <= clear_ptr_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      oob_q       <= oob_d;
    end
  end

  // Storage is deliberately not reset; the sweep is what zeroes it.
  always_ff @(posedge clock) begin
    if (mem_we_s) begin
      mem[mem_waddr_s] <= mem_wdata_s;
    end
  end

  buffer_ram_rdpipe #(
    .DATA_W  (DATA_W),
    .READ_LAT(READ_LAT)
  ) u_rdpipe (
    .clock    (clock),
    .reset    (reset),
    .in_valid (rd_fire_s),
    .in_data  (rd_word_s),
    .out_valid(read_valid),
    .out_data (read_data)
  );

  assign ready     = ready_q;
  assign busy      = busy_q;
  assign oob_error = oob_q;

endmodule
